uart_tx_scheduler: RTL and testbench

//  Packet-level round-robin scheduler sharing one UART TX FIFO write port among N_REQ byte-stream

---
 rtl/uart_tx_scheduler_pkg.sv | 20 ++
 rtl/uart_tx_scheduler_if.sv | 29 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 111 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// uart_sched_pkg: shared types and helpers for the UART TX packet scheduler.
//   sched_state_e  - scheduler FSM states
//   HDR_SYNC_DEF   - default upper nibble of the per-chunk header byte
//   make_hdr()     - builds a header byte from sync nibble and source index
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } sched_state_e;

  localparam logic [3:0] HDR_SYNC_DEF = 4'hA;

  function automatic logic [7:0] make_hdr(input logic [3:0] src,
                                          input logic [3:0] sync = HDR_SYNC_DEF);
    return {sync, src};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester byte streams plus the TX FIFO write port.
//   req_valid/req_data/req_last  - per-requester byte stream (byte i at [8*i+7:8*i])
//   req_ready                    - per-requester accept
//   fifo_full                    - TX FIFO full
//   fifo_wr_en/fifo_wr_data      - TX FIFO write port
// Modports: master = requesters + FIFO side, slave = scheduler.
interface uart_tx_scheduler_if #(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [7:0]         fifo_wr_data;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req         - request vector
//   i_last_grant  - index served last; search starts at i_last_grant+1
//   o_gnt_idx     - winning index (0 when none)
//   o_gnt_valid   - at least one request present
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last_grant,
  output logic [W-1:0] o_gnt_idx,
  output logic         o_gnt_valid
);

  int unsigned      w_pos;
  logic [W-1:0]     w_idx;

  always_comb begin
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    w_pos       = 0;
    w_idx       = '0;
    // Offsets 1..N so the last winner is considered only after everyone else.
    for (int k = 1; k <= N; k++) begin
      w_pos = (int'(i_last_grant) + k) % N;
      w_idx = W'(w_pos);
      if (!o_gnt_valid && i_req[w_idx]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART TX FIFO write port among N_REQ byte-stream
// requesters. Each granted chunk is prefixed by a header byte {HDR_SYNC, src}.
//   clk          - scheduler clock (TX FIFO write clock)
//   rst          - asynchronous active-high reset
//   bus          - requester streams and FIFO write port (slave modport)
//   grant_o      - current/last granted requester index
//   busy_o       - FSM not in IDLE
//   pkt_count_o  - completed chunks, wraps at 16 bits
//
// state   | meaning
// IDLE    | waiting for any requester; arbitrates and latches the winner
// HEADER  | writing the header byte for the granted source
// PAYLOAD | forwarding granted bytes until last or MAX_PAYLOAD bytes
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter  int         N_REQ       = 4,
  parameter  int         MAX_PAYLOAD = 64,
  parameter  logic [3:0] HDR_SYNC    = HDR_SYNC_DEF,
  localparam int         SRC_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_scheduler_if.slave   bus,
  output logic [SRC_W-1:0]     grant_o,
  output logic                 busy_o,
  output logic [15:0]          pkt_count_o
);

  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  logic [SRC_W-1:0] r_grant;
  logic [SRC_W-1:0] r_last_grant;
  logic [7:0]       r_byte_cnt;
  logic [15:0]      r_pkt_count;

  logic [SRC_W-1:0] w_arb_idx;
  logic             w_arb_valid;
  logic             w_accept;
  logic             w_chunk_end;
  logic [7:0]       w_req_byte [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign w_req_byte[g] = bus.req_data[8*g +: 8];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_gnt_idx    (w_arb_idx),
    .o_gnt_valid  (w_arb_valid)
  );

  // Write enable and ready are gated by fifo_full combinationally so a write
  // can never land on a full FIFO.
  always_comb begin
    w_state_nxt      = r_state;
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    w_accept         = 1'b0;
    w_chunk_end      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) w_state_nxt = HEADER;
      end
      HEADER: begin
        bus.fifo_wr_en   = !bus.fifo_full;
        bus.fifo_wr_data = make_hdr(4'(r_grant), HDR_SYNC);
        if (!bus.fifo_full) w_state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        bus.req_ready[r_grant] = !bus.fifo_full;
        w_accept               = bus.req_valid[r_grant] & !bus.fifo_full;
        bus.fifo_wr_en         = w_accept;
        bus.fifo_wr_data       = w_req_byte[r_grant];
        // last and the size limit coinciding is still a single chunk end
        w_chunk_end = w_accept &
                      (bus.req_last[r_grant] | ((r_byte_cnt + 8'd1) == 8'(MAX_PAYLOAD)));
        if (w_chunk_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= SRC_W'(N_REQ - 1);
      r_byte_cnt   <= '0;
      r_pkt_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_arb_valid) begin
        r_grant    <= w_arb_idx;
        r_byte_cnt <= '0;
      end
      if (w_accept) r_byte_cnt <= r_byte_cnt + 8'd1;
      if (w_chunk_end) begin
        r_last_grant <= r_grant;
        r_pkt_count  <= r_pkt_count + 16'd1;
      end
    end
  end

  assign grant_o     = r_grant;
  assign busy_o      = (r_state != IDLE);
  assign pkt_count_o = r_pkt_count;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (N_REQ=4, MAX_PAYLOAD=4).
module tb_uart_tx_scheduler;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] pkt;

  uart_tx_scheduler_if #(.N_REQ(N)) bus ();

  uart_tx_scheduler #(.N_REQ(N), .MAX_PAYLOAD(4), .HDR_SYNC(4'hA)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .grant_o     (grant),
    .busy_o      (busy),
    .pkt_count_o (pkt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0]   q_data [N][$];
  logic         q_last [N][$];
  logic [N-1:0] hold = '0;
  logic [N-1:0] acc  = '0;
  logic [7:0]   log_q [$];
  int           log_cyc [$];
  int           first_vld_cyc = -1;
  logic [7:0]   e [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] b[$]);
    for (int k = 0; k < b.size(); k++) begin
      q_data[r].push_back(b[k]);
      q_last[r].push_back(k == b.size() - 1);
    end
  endtask

  function automatic bit all_empty();
    bit v = 1'b1;
    for (int i = 0; i < N; i++) if (q_data[i].size() != 0) v = 1'b0;
    return v;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 300) begin
      step();
      n++;
      done = (busy == 1'b0) && all_empty();
    end
    check({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic wait_log(input int cnt, input string tag);
    int n = 0;
    while (log_q.size() < cnt && n < 300) begin
      step();
      n++;
    end
    check({tag, "_wait_log"}, 32'(log_q.size() >= cnt), 32'd1);
  endtask

  task automatic check_log(input string tag, input logic [7:0] exp[$]);
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < log_q.size())
        check($sformatf("%s[%0d]", tag, i), 32'(log_q[i]), 32'(exp[i]));
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  // Requester and FIFO-side model: drives streams on negedge, samples the
  // handshake just before the next posedge.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (acc[i] && q_data[i].size() > 0) begin
          void'(q_data[i].pop_front());
          void'(q_last[i].pop_front());
        end
      for (int i = 0; i < N; i++) begin
        if (q_data[i].size() > 0 && !hold[i]) begin
          bus.req_valid[i]      = 1'b1;
          bus.req_data[8*i +: 8] = q_data[i][0];
          bus.req_last[i]       = q_last[i][0];
        end else begin
          bus.req_valid[i]      = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]       = 1'b0;
        end
      end
      if (|bus.req_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      #2;
      acc = bus.req_valid & bus.req_ready;
      if (bus.fifo_wr_en) begin
        log_q.push_back(bus.fifo_wr_data);
        log_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.fifo_full = 1'b0;
    step();
    step();

    // reset state
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_pkt",   32'(pkt), 32'd0);
    check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    step();

    // 1: req0 sends 11,22,33
    clear_log();
    first_vld_cyc = -1;
    e = '{8'h11, 8'h22, 8'h33};
    push(0, e);
    drain("t1");
    e = '{8'hA0, 8'h11, 8'h22, 8'h33};
    check_log("t1_log", e);
    if (log_cyc.size() >= 4) begin
      check("t1_hdr_lat",  32'(log_cyc[0] - first_vld_cyc), 32'd1);
      check("t1_b0_lat",   32'(log_cyc[1] - first_vld_cyc), 32'd2);
      check("t1_last_lat", 32'(log_cyc[3] - first_vld_cyc), 32'd4);
    end
    check("t1_pkt",   32'(pkt), 32'd1);
    check("t1_grant", 32'(grant), 32'd0);

    // 2: req1 and req2 together from reset, then req0 before req1
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    clear_log();
    e = '{8'h31, 8'h32}; push(1, e);
    e = '{8'h41, 8'h42}; push(2, e);
    drain("t2a");
    e = '{8'hA1, 8'h31, 8'h32, 8'hA2, 8'h41, 8'h42};
    check_log("t2a_log", e);
    check("t2a_pkt", 32'(pkt), 32'd2);
    clear_log();
    e = '{8'h61, 8'h62}; push(1, e);
    e = '{8'h51, 8'h52}; push(0, e);
    drain("t2b");
    e = '{8'hA0, 8'h51, 8'h52, 8'hA1, 8'h61, 8'h62};
    check_log("t2b_log", e);
    check("t2b_pkt",   32'(pkt), 32'd4);
    check("t2b_grant", 32'(grant), 32'd1);

    // 3: FIFO full for 5 cycles, covering the cycle that offers the last byte
    clear_log();
    e = '{8'h81, 8'h82, 8'h83};
    push(2, e);
    wait_log(3, "t3");
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t3_full_wr_en%0d", k), 32'(bus.fifo_wr_en), 32'd0);
      check($sformatf("t3_full_ready%0d", k), 32'(bus.req_ready), 32'd0);
      check($sformatf("t3_full_busy%0d", k),  32'(busy), 32'd1);
      step();
    end
    bus.fifo_full = 1'b0;
    drain("t3");
    e = '{8'hA2, 8'h81, 8'h82, 8'h83};
    check_log("t3_log", e);
    check("t3_pkt", 32'(pkt), 32'd5);

    // 4: req3 streams 10 bytes split into chunks of 4, req0 interleaves
    clear_log();
    e = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98, 8'h99};
    push(3, e);
    e = '{8'hC0, 8'hC1};
    push(0, e);
    drain("t4");
    e = '{8'hA3, 8'h90, 8'h91, 8'h92, 8'h93,
          8'hA0, 8'hC0, 8'hC1,
          8'hA3, 8'h94, 8'h95, 8'h96, 8'h97,
          8'hA3, 8'h98, 8'h99};
    check_log("t4_log", e);
    check("t4_pkt", 32'(pkt), 32'd9);

    // 4b: last coincides with the size limit -> one chunk
    clear_log();
    e = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    push(1, e);
    drain("t4b");
    e = '{8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    check_log("t4b_log", e);
    check("t4b_pkt", 32'(pkt), 32'd10);

    // 5: reset in PAYLOAD after 2 bytes
    clear_log();
    e = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
    push(2, e);
    wait_log(3, "t5");
    rst = 1'b1;
    #1;
    check("t5_busy",  32'(busy), 32'd0);
    check("t5_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check("t5_data",  32'(bus.fifo_wr_data), 32'd0);
    check("t5_ready", 32'(bus.req_ready), 32'd0);
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_pkt",   32'(pkt), 32'd0);
    q_data[2].delete();
    q_last[2].delete();
    step();
    rst = 1'b0;
    step();
    clear_log();
    e = '{8'hF1}; push(3, e);
    e = '{8'hF0}; push(0, e);
    drain("t5b");
    e = '{8'hA0, 8'hF0, 8'hA3, 8'hF1};
    check_log("t5b_log", e);
    check("t5b_pkt", 32'(pkt), 32'd2);

    // 6: requester drops valid after the grant for 10 cycles
    clear_log();
    e = '{8'hD0, 8'hD1};
    push(1, e);
    n = 0;
    while (busy == 1'b0 && n < 50) begin
      step();
      n++;
    end
    check("t6_started", 32'(busy), 32'd1);
    hold[1] = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t6_stall_wr_en%0d", k), 32'(bus.fifo_wr_en), 32'd0);
      check($sformatf("t6_stall_busy%0d", k),  32'(busy), 32'd1);
      check($sformatf("t6_stall_log%0d", k),   32'(log_q.size()), 32'd1);
      step();
    end
    check("t6_ready", 32'(bus.req_ready), 32'b0010);
    hold[1] = 1'b0;
    drain("t6");
    e = '{8'hA1, 8'hD0, 8'hD1};
    check_log("t6_log", e);
    check("t6_pkt", 32'(pkt), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
